// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the pipeline control blocks.
//   mdState_t  : state of the shared multiply/divide unit sequencer
//   REG_W_DEF  : default register-index width of the pipeline fields
//   NOP_INSTR  : instruction word loaded into IF/ID on a flush
package cpu_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } mdState_t;

  localparam int REG_W_DEF = 6;

  // sll $0,$0,0 -- the canonical all-zero NOP
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active-high (count -> 0)
//   inc    : count one event this cycle
//   clr    : synchronous clear, wins over inc
//   count  : current value
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: per-cycle sequencing of PC and IF/ID for the 5-stage pipeline.
// Detects load-use hazards, flushes on branches taken in EX, and issues /
// tracks the shared multi-cycle multiply/divide unit.
//   clk_i, rst_i         : clock (rising) and asynchronous active-high reset
//   Id_RegRs/Id_RegRt    : source register indices of the instruction in ID
//   Id_useRt             : ID instruction actually reads rt
//   Id_mdOp/Id_hiloRead  : ID instruction is mult/div, or mfhi/mflo
//   Ex_memRead/Ex_RegRt  : EX instruction is a load and its destination
//   Ex_branchTaken       : branch/jump in EX resolved taken
//   cnt_clr_i            : clear both performance counters
//   pcWrite/ifidWrite    : register enables
//   ifidFlush/idexFlush  : load NOP into IF/ID, bubble into ID/EX
//   md_start/md_busy     : MD issue pulse and busy indication
//   stall_cnt/flush_cnt  : saturating event counters
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] Id_RegRs,
  input  logic [REG_W-1:0] Id_RegRt,
  input  logic             Id_useRt,
  input  logic             Id_mdOp,
  input  logic             Id_hiloRead,
  input  logic             Ex_memRead,
  input  logic [REG_W-1:0] Ex_RegRt,
  input  logic             Ex_branchTaken,
  input  logic             cnt_clr_i,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Busy countdown is loaded with MD_LAT-1 so BUSY lasts exactly MD_LAT cycles.
  localparam logic [7:0] MD_LAT_M1 = 8'(MD_LAT - 1);

  mdState_t   stateReg, stateNext;
  logic [7:0] cntReg, cntNext;

  logic loadUse;
  logic mdHazard;
  logic stall;

  // $0 is hard-wired zero, so a load targeting it never creates a dependence.
  assign loadUse = Ex_memRead && (Ex_RegRt != '0) &&
                   ((Ex_RegRt == Id_RegRs) || (Id_useRt && (Ex_RegRt == Id_RegRt)));

  assign md_busy  = (stateReg == MD_BUSY);
  assign mdHazard = md_busy && (Id_mdOp || Id_hiloRead);

  // A taken branch kills the ID instruction, so its hazards are irrelevant.
  assign stall = (loadUse || mdHazard) && !Ex_branchTaken;

  assign md_start = Id_mdOp && !stall && !Ex_branchTaken && (stateReg == MD_IDLE);

  always_comb begin
    pcWrite   = 1'b1;
    ifidWrite = 1'b1;
    ifidFlush = 1'b0;
    idexFlush = 1'b0;
    if (Ex_branchTaken) begin
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
    end else if (stall) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      idexFlush = 1'b1;
    end
  end

  // MD sequencer. A branch flush does not touch it: the op already issued
  // is older than the branch and must complete.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateReg <= MD_IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      MD_IDLE: begin
        if (md_start) begin
          stateNext = MD_BUSY;
          cntNext   = MD_LAT_M1;
        end
      end
      MD_BUSY: begin
        if (cntReg == 8'd0) begin
          stateNext = MD_IDLE;
        end else begin
          cntNext = cntReg - 8'd1;
        end
      end
      default: begin
        stateNext = MD_IDLE;
        cntNext   = '0;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) stallCounter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (stall),
    .clr   (cnt_clr_i),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) flushCounter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (Ex_branchTaken),
    .clr   (cnt_clr_i),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, directed corner sequences and random
// stimulus against a cycle-level reference model of hazard_ctrl.
module tb_hazard_ctrl;

  localparam int REG_W   = 6;
  localparam int MD_LAT  = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] rs, rt, exRt;
  logic             useRt, mdOp, hilo, memRead, br, clr;
  logic             pcWrite, ifidWrite, ifidFlush, idexFlush, md_start, md_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.REG_W(REG_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .Id_RegRs       (rs),
    .Id_RegRt       (rt),
    .Id_useRt       (useRt),
    .Id_mdOp        (mdOp),
    .Id_hiloRead    (hilo),
    .Ex_memRead     (memRead),
    .Ex_RegRt       (exRt),
    .Ex_branchTaken (br),
    .cnt_clr_i      (clr),
    .pcWrite        (pcWrite),
    .ifidWrite      (ifidWrite),
    .ifidFlush      (ifidFlush),
    .idexFlush      (idexFlush),
    .md_start       (md_start),
    .md_busy        (md_busy),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: MD unit as "cycles of busy remaining", counters as ints.
  int mdRem  = 0;
  int stallM = 0;
  int flushM = 0;
  bit eStall, eStart;

  typedef struct {
    int rs, rt, useRt, mdOp, hilo, memRead, exRt, br;
    int pc, ifid, ifidF, idexF, start;
  } tv_t;

  tv_t tbl[11];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic modelComb();
    bit lu, busy;
    lu     = memRead && (exRt != 0) && ((exRt == rs) || (useRt && (exRt == rt)));
    busy   = (mdRem > 0);
    eStall = (lu || (busy && (mdOp || hilo))) && !br;
    eStart = mdOp && !eStall && !br && !busy;
  endtask

  task automatic checkComb();
    modelComb();
    chk("pcWrite",   int'(pcWrite),   int'(!eStall));
    chk("ifidWrite", int'(ifidWrite), int'(!eStall));
    chk("ifidFlush", int'(ifidFlush), int'(br));
    chk("idexFlush", int'(idexFlush), int'(br || eStall));
    chk("md_start",  int'(md_start),  int'(eStart));
  endtask

  // Advance one clock edge, update the model and check registered state.
  task automatic tick();
    bit s, f, st, c;
    modelComb();
    s = eStall; f = br; st = eStart; c = clr;
    @(posedge clk);
    #1;
    if (st) mdRem = MD_LAT;
    else if (mdRem > 0) mdRem--;
    if (c) begin
      stallM = 0; flushM = 0;
    end else begin
      if (s && stallM < CNT_MAX) stallM++;
      if (f && flushM < CNT_MAX) flushM++;
    end
    chk("md_busy",   int'(md_busy),   int'(mdRem > 0));
    chk("stall_cnt", int'(stall_cnt), stallM);
    chk("flush_cnt", int'(flush_cnt), flushM);
  endtask

  task automatic runCycle();
    #1;
    checkComb();
    tick();
  endtask

  task automatic zeroIn();
    rs = '0; rt = '0; exRt = '0;
    useRt = 0; mdOp = 0; hilo = 0; memRead = 0; br = 0; clr = 0;
  endtask

  task automatic drain();
    zeroIn();
    for (int i = 0; i < MD_LAT + 5; i++) begin
      if (mdRem == 0) break;
      runCycle();
    end
    chk("drain_idle", int'(md_busy), 0);
  endtask

  initial begin
    int stallN, busyN;
    rst = 1'b1;
    zeroIn();
    #2;
    chk("rst_pcWrite",   int'(pcWrite),   1);
    chk("rst_ifidWrite", int'(ifidWrite), 1);
    chk("rst_flushes",   int'(ifidFlush | idexFlush), 0);
    chk("rst_md_start",  int'(md_start),  0);
    chk("rst_md_busy",   int'(md_busy),   0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_flush_cnt", int'(flush_cnt), 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // ---- vector table (MD unit idle at each entry) ----
    //         rs rt uRt md hl mR exRt br | pc ifid ifF idF start
    tbl[0]  = '{5, 0, 0, 0, 0, 1, 5, 0,  0, 0, 0, 1, 0}; // load-use on rs
    tbl[1]  = '{0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0}; // load to $0
    tbl[2]  = '{3, 7, 0, 0, 0, 1, 7, 0,  1, 1, 0, 0, 0}; // rt not read
    tbl[3]  = '{3, 7, 1, 0, 0, 1, 7, 0,  0, 0, 0, 1, 0}; // rt read
    tbl[4]  = '{5, 0, 0, 0, 0, 1, 5, 1,  1, 1, 1, 1, 0}; // branch beats stall
    tbl[5]  = '{5, 9, 1, 0, 0, 0, 5, 0,  1, 1, 0, 0, 0}; // not a load
    tbl[6]  = '{0, 0, 1, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0}; // $0 everywhere
    tbl[7]  = '{2, 0, 0, 1, 0, 0, 0, 1,  1, 1, 1, 1, 0}; // md op killed
    tbl[8]  = '{5, 0, 0, 1, 0, 1, 5, 0,  0, 0, 0, 1, 0}; // md op load-stalled
    tbl[9]  = '{2, 3, 1, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0}; // mfhi while idle
    tbl[10] = '{4, 6, 1, 1, 0, 1, 9, 0,  1, 1, 0, 0, 1}; // md op issues
    for (int i = 0; i < 11; i++) begin
      rs = REG_W'(tbl[i].rs); rt = REG_W'(tbl[i].rt); exRt = REG_W'(tbl[i].exRt);
      useRt = tbl[i].useRt[0]; mdOp = tbl[i].mdOp[0]; hilo = tbl[i].hilo[0];
      memRead = tbl[i].memRead[0]; br = tbl[i].br[0]; clr = 0;
      #1;
      chk($sformatf("tbl%0d_pcWrite", i),   int'(pcWrite),   tbl[i].pc);
      chk($sformatf("tbl%0d_ifidWrite", i), int'(ifidWrite), tbl[i].ifid);
      chk($sformatf("tbl%0d_ifidFlush", i), int'(ifidFlush), tbl[i].ifidF);
      chk($sformatf("tbl%0d_idexFlush", i), int'(idexFlush), tbl[i].idexF);
      chk($sformatf("tbl%0d_md_start", i),  int'(md_start),  tbl[i].start);
      tick();
    end
    drain();

    // ---- MD latency, mfhi waiting, back-to-back issue ----
    zeroIn();
    mdOp = 1;
    #1;
    chk("md_issue_pulse", int'(md_start), 1);
    tick();
    mdOp = 0; hilo = 1;
    stallN = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      checkComb();
      if (pcWrite) break;
      stallN++;
      tick();
    end
    chk("hilo_stall_cycles", stallN, MD_LAT);
    hilo = 0; mdOp = 1;
    #1;
    chk("md_back_to_back", int'(md_start), 1);
    checkComb();
    tick();
    zeroIn();
    busyN = 0;
    for (int i = 0; i < 20; i++) begin
      if (!md_busy) break;
      busyN++;
      runCycle();
    end
    chk("md_busy_cycles", busyN, MD_LAT);

    // ---- asynchronous reset in the second BUSY cycle ----
    memRead = 1; exRt = 5; rs = 5;
    runCycle();
    zeroIn(); br = 1;
    runCycle();
    zeroIn(); mdOp = 1;
    runCycle();
    zeroIn();
    runCycle();
    #1 rst = 1'b1;
    #1;
    chk("arst_md_busy",   int'(md_busy),   0);
    chk("arst_stall_cnt", int'(stall_cnt), 0);
    chk("arst_flush_cnt", int'(flush_cnt), 0);
    mdRem = 0; stallM = 0; flushM = 0;
    #1 rst = 1'b0;
    mdOp = 1;
    #1;
    chk("arst_reissue", int'(md_start), 1);
    checkComb();
    tick();
    drain();

    // ---- counter saturation and clear-over-increment ----
    zeroIn(); clr = 1;
    runCycle();
    clr = 0; memRead = 1; exRt = 5; rs = 5;
    for (int i = 0; i < 20; i++) runCycle();
    chk("sat_stall_cnt", int'(stall_cnt), CNT_MAX);
    clr = 1;
    runCycle();
    chk("clr_over_stall", int'(stall_cnt), 0);

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      rs      = REG_W'($urandom_range(0, 3));
      rt      = REG_W'($urandom_range(0, 3));
      exRt    = REG_W'($urandom_range(0, 3));
      useRt   = ($urandom_range(0, 1) == 1);
      memRead = ($urandom_range(0, 2) == 0);
      mdOp    = ($urandom_range(0, 5) == 0);
      hilo    = ($urandom_range(0, 5) == 0);
      br      = ($urandom_range(0, 7) == 0);
      clr     = ($urandom_range(0, 19) == 0);
      runCycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
